// File: rtl/multdiv_issue_ctrl_if.sv
// Decode-side request, multiply/divide unit and writeback signals of the mult/div issue controller.
`timescale 1ns/1ps
interface multdiv_issue_ctrl_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  logic              issue_mult;
  logic              issue_div;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [RD_W-1:0]   issue_rd;
  logic              flush;
  logic              issue_ready;
  logic              stall;
  logic [DATA_W-1:0] md_operandA;
  logic [DATA_W-1:0] md_operandB;
  logic              md_ctrl_MULT;
  logic              md_ctrl_DIV;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_resultRDY;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exception;
  logic              timeout_err;
  logic              issue_err;

  // Controller side
  modport slave (
    input  issue_mult, issue_div, issue_a, issue_b, issue_rd, flush,
    input  md_result, md_exception, md_resultRDY,
    output issue_ready, stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output wb_valid, wb_rd, wb_data, wb_exception, timeout_err, issue_err
  );

  // Pipeline / unit environment side
  modport master (
    output issue_mult, issue_div, issue_a, issue_b, issue_rd, flush,
    output md_result, md_exception, md_resultRDY,
    input  issue_ready, stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  wb_valid, wb_rd, wb_data, wb_exception, timeout_err, issue_err
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issues one mult/div op to the multi-cycle unit, holds operands, stalls until ready
// (or timeout), then produces a single writeback of the result or an exception code.
`timescale 1ns/1ps
module multdiv_issue_ctrl #(
  parameter int unsigned STATUS_REG     = 30,
  parameter int unsigned MULT_EXC_CODE  = 4,
  parameter int unsigned DIV_EXC_CODE   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input logic                 clock,
  input logic                 reset,
  multdiv_issue_ctrl_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_div_q, op_div_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              ctrl_mult_q, ctrl_mult_d, ctrl_div_q, ctrl_div_d;
  logic              wb_en_q, wb_en_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_exc_q, wb_exc_d;
  logic              timeout_q, timeout_d;
  logic              issue_err_q, issue_err_d;
  logic              ready_c, accept_c;
  logic [DATA_W-1:0] exc_code_c;

  assign ready_c    = ~reset & ~bus.flush & ((state_q == IDLE) | (state_q == DONE));
  assign accept_c   = ready_c & (bus.issue_mult ^ bus.issue_div);
  assign exc_code_c = op_div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);

  // Next-state and next-register values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_div_d    = op_div_q;
    rd_d        = rd_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    wb_en_d     = wb_en_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_exc_d    = wb_exc_q;
    timeout_d   = 1'b0;
    issue_err_d = ready_c & bus.issue_mult & bus.issue_div;

    case (state_q)
      IDLE: state_d = IDLE;
      // Ready is not looked at here: it may still be the previous op's pulse
      START: begin
        cnt_d   = '0;
        state_d = bus.flush ? IDLE : BUSY;
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.md_resultRDY || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d   = DONE;
          timeout_d = ~bus.md_resultRDY;
          if (~bus.md_resultRDY | bus.md_exception) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = RD_W'(STATUS_REG);
            wb_data_d = exc_code_c;
            wb_exc_d  = 1'b1;
          end else if (rd_q != '0) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = bus.md_result;
            wb_exc_d  = 1'b0;
          end else begin
            wb_en_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      state_d     = START;
      op_div_d    = bus.issue_div;
      rd_d        = bus.issue_rd;
      op_a_d      = bus.issue_a;
      op_b_d      = bus.issue_b;
      ctrl_mult_d = bus.issue_mult;
      ctrl_div_d  = bus.issue_div;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_div_q    <= 1'b0;
      rd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_exc_q    <= 1'b0;
      timeout_q   <= 1'b0;
      issue_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_div_q    <= op_div_d;
      rd_q        <= rd_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_exc_q    <= wb_exc_d;
      timeout_q   <= timeout_d;
      issue_err_q <= issue_err_d;
    end
  end

  // A flush in the writeback cycle still kills the strobe
  assign bus.issue_ready  = ready_c;
  assign bus.stall        = (state_q == START) | (state_q == BUSY) | accept_c;
  assign bus.wb_valid     = (state_q == DONE) & wb_en_q & ~bus.flush;
  assign bus.md_operandA  = op_a_q;
  assign bus.md_operandB  = op_b_q;
  assign bus.md_ctrl_MULT = ctrl_mult_q;
  assign bus.md_ctrl_DIV  = ctrl_div_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_exception = wb_exc_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.issue_err    = issue_err_q;
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: directed scenarios plus random traffic, checked every cycle
// against a transaction-level reference model driving a latency model of the mult/div unit.
`timescale 1ns/1ps
module tb_multdiv_issue_ctrl;
  localparam int MULT_LAT = 17;
  localparam int DIV_LAT  = 32;
  localparam int TIMEOUT  = 40;

  logic clk;
  logic rst;

  multdiv_issue_ctrl_if bus();

  multdiv_issue_ctrl dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: the op in flight and the pending writeback
  bit          m_inflight, m_div, m_done, m_done_en, m_done_to, m_ierr, m_wb_exc;
  int          m_acc;
  logic [4:0]  m_rd, m_wb_rd;
  logic [31:0] m_opA, m_opB, m_wb_data;

  // Unit latency model and stimulus knobs
  int          u_rdy_cyc = -1;
  logic [31:0] u_res;
  bit          u_exc, u_mute, u_exc_force, stray_req;

  // Observations of the DUT for directed scenario checks
  int          n_wb, n_ctrl_mult, n_ctrl_div, n_to, n_ierr, ctrl_mult_cyc;
  logic [4:0]  last_wb_rd;
  logic [31:0] last_wb_data;
  bit          last_wb_exc;
  logic [31:0] wb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (sa == 32'sh80000000 && sb == -32'sd1) return a;
    return sa / sb;
  endfunction

  task automatic clr_obs();
    n_wb = 0; n_ctrl_mult = 0; n_ctrl_div = 0; n_to = 0; n_ierr = 0; ctrl_mult_cyc = -1;
    last_wb_rd = '0; last_wb_data = '0; last_wb_exc = 1'b0;
    wb_q.delete();
  endtask

  task automatic model_reset();
    m_inflight = 0; m_done = 0; m_done_en = 0; m_done_to = 0; m_ierr = 0; m_div = 0;
    m_opA = '0; m_opB = '0; m_rd = '0; m_acc = -100;
    u_rdy_cyc = -1;
  endtask

  task automatic drive_zero();
    bus.issue_mult = 0; bus.issue_div = 0; bus.issue_a = '0; bus.issue_b = '0; bus.issue_rd = '0;
    bus.flush = 0; bus.md_resultRDY = 0; bus.md_result = '0; bus.md_exception = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, bus.issue_ready, 0);
    check_eq({tag, "_stall"}, bus.stall, 0);
    check_eq({tag, "_ctrl_mult"}, bus.md_ctrl_MULT, 0);
    check_eq({tag, "_ctrl_div"}, bus.md_ctrl_DIV, 0);
    check_eq({tag, "_opA"}, bus.md_operandA, 0);
    check_eq({tag, "_opB"}, bus.md_operandB, 0);
    check_eq({tag, "_wb_valid"}, bus.wb_valid, 0);
    check_eq({tag, "_wb_rd"}, bus.wb_rd, 0);
    check_eq({tag, "_wb_data"}, bus.wb_data, 0);
    check_eq({tag, "_wb_exc"}, bus.wb_exception, 0);
    check_eq({tag, "_timeout"}, bus.timeout_err, 0);
    check_eq({tag, "_issue_err"}, bus.issue_err, 0);
  endtask

  // One clock cycle: drive at negedge, check just after, then advance the model past the edge
  task automatic step_cycle(input bit im, input bit id, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input bit fl);
    bit rdy, stray, exc_in, e_ready, e_acc, e_start, e_wb;
    logic [31:0] res_in;
    @(negedge clk);
    stray     = stray_req;
    stray_req = 0;
    rdy       = (cyc == u_rdy_cyc) || stray;
    res_in    = (cyc == u_rdy_cyc) ? u_res : $urandom();
    exc_in    = (cyc == u_rdy_cyc) ? u_exc : 1'b0;
    bus.issue_mult = im; bus.issue_div = id; bus.issue_a = a; bus.issue_b = b; bus.issue_rd = rd;
    bus.flush = fl; bus.md_resultRDY = rdy; bus.md_result = res_in; bus.md_exception = exc_in;
    #1;
    e_ready = !m_inflight && !fl;
    e_acc   = e_ready && (im != id);
    e_start = m_inflight && (cyc == m_acc + 1);
    e_wb    = m_done && m_done_en && !fl;
    check_eq("issue_ready", bus.issue_ready, e_ready);
    check_eq("stall", bus.stall, m_inflight || e_acc);
    check_eq("ctrl_mult", bus.md_ctrl_MULT, e_start && !m_div);
    check_eq("ctrl_div", bus.md_ctrl_DIV, e_start && m_div);
    check_eq("wb_valid", bus.wb_valid, e_wb);
    check_eq("timeout_err", bus.timeout_err, m_done && m_done_to);
    check_eq("issue_err", bus.issue_err, m_ierr);
    check_eq("operandA", bus.md_operandA, m_opA);
    check_eq("operandB", bus.md_operandB, m_opB);
    if (e_wb) begin
      check_eq("wb_rd", bus.wb_rd, m_wb_rd);
      check_eq("wb_data", bus.wb_data, m_wb_data);
      check_eq("wb_exception", bus.wb_exception, m_wb_exc);
    end
    if (bus.wb_valid) begin
      n_wb++; last_wb_rd = bus.wb_rd; last_wb_data = bus.wb_data; last_wb_exc = bus.wb_exception;
      wb_q.push_back(bus.wb_data);
    end
    if (bus.md_ctrl_MULT) begin n_ctrl_mult++; ctrl_mult_cyc = cyc; end
    if (bus.md_ctrl_DIV) n_ctrl_div++;
    if (bus.timeout_err) n_to++;
    if (bus.issue_err) n_ierr++;
    // Unit reacts to a start pulse by scheduling its one-cycle ready
    if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
      u_rdy_cyc = u_mute ? -1 : cyc + (bus.md_ctrl_DIV ? DIV_LAT : MULT_LAT);
      if (bus.md_ctrl_DIV) begin
        u_exc = (bus.md_operandB == 0) || u_exc_force;
        u_res = u_exc ? 32'd0 : sdiv(bus.md_operandA, bus.md_operandB);
      end else begin
        u_exc = u_exc_force;
        u_res = 32'($signed(bus.md_operandA) * $signed(bus.md_operandB));
      end
    end
    // Model advance
    m_ierr = e_ready && im && id;
    m_done = 0;
    if (m_inflight) begin
      if (fl) begin
        m_inflight = 0;
      end else if (cyc >= m_acc + 2 && (rdy || cyc == m_acc + 1 + TIMEOUT)) begin
        m_inflight = 0;
        m_done     = 1;
        m_done_to  = !rdy;
        if (!rdy || exc_in) begin
          m_done_en = 1; m_wb_rd = 5'd30; m_wb_data = m_div ? 32'd5 : 32'd4; m_wb_exc = 1;
        end else begin
          m_done_en = (m_rd != 0); m_wb_rd = m_rd; m_wb_data = res_in; m_wb_exc = 0;
        end
      end
    end
    if (e_acc) begin
      m_inflight = 1; m_acc = cyc; m_div = id; m_rd = rd; m_opA = a; m_opB = b;
    end
    cyc++;
  endtask

  task automatic idle();
    step_cycle(1'b0, 1'b0, $urandom(), $urandom(), 5'($urandom()), 1'b0);
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!m_done && n < max_cyc) begin idle(); n++; end
    check_eq("done_reached", m_done, 1'b1);
    idle();
  endtask

  initial begin
    int n, done_cyc, r;
    bit im, id;
    clr_obs();
    model_reset();
    u_mute = 0; u_exc_force = 0; stray_req = 0;
    drive_zero();
    rst = 1'b0;
    #2 rst = 1'b1;
    #3 check_all_zero("reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Mult 7 x -3 into r5; issue_a churns while busy
    clr_obs();
    step_cycle(1, 0, 32'd7, 32'hFFFFFFFD, 5'd5, 0);
    wait_done(60);
    check_eq("mult_ctrl_cnt", n_ctrl_mult, 1);
    check_eq("mult_wb_cnt", n_wb, 1);
    check_eq("mult_wb_rd", last_wb_rd, 5);
    check_eq("mult_wb_data", last_wb_data, 32'hFFFFFFEB);
    check_eq("mult_opA_hold", bus.md_operandA, 32'd7);
    check_eq("mult_opB_hold", bus.md_operandB, 32'hFFFFFFFD);

    // Div by zero with exception
    clr_obs();
    step_cycle(0, 1, 32'd100, 32'd0, 5'd8, 0);
    wait_done(60);
    check_eq("divz_wb_cnt", n_wb, 1);
    check_eq("divz_wb_rd", last_wb_rd, 30);
    check_eq("divz_wb_data", last_wb_data, 5);
    check_eq("divz_wb_exc", last_wb_exc, 1);

    // Normal result to r0 is not written back
    clr_obs();
    step_cycle(0, 1, 32'd100, 32'd7, 5'd0, 0);
    wait_done(60);
    check_eq("rd0_ctrl_div", n_ctrl_div, 1);
    check_eq("rd0_wb_cnt", n_wb, 0);

    // Back-to-back: mult issued in the div's writeback cycle, stale ready in its START
    clr_obs();
    step_cycle(0, 1, 32'd100, 32'd7, 5'd9, 0);
    n = 0;
    while (!m_done && n < 60) begin idle(); n++; end
    check_eq("b2b_done_reached", m_done, 1'b1);
    done_cyc = cyc;
    step_cycle(1, 0, 32'd6, 32'd7, 5'd11, 0);
    stray_req = 1;
    wait_done(60);
    check_eq("b2b_wb_cnt", wb_q.size(), 2);
    if (wb_q.size() >= 2) begin
      check_eq("b2b_div_data", wb_q[0], 14);
      check_eq("b2b_mult_data", wb_q[1], 42);
    end
    check_eq("b2b_ctrl_cyc", ctrl_mult_cyc, done_cyc + 1);
    check_eq("b2b_ctrl_cnt", n_ctrl_mult, 1);

    // Flush on the same cycle as ready
    clr_obs();
    step_cycle(1, 0, 32'd3, 32'd4, 5'd6, 0);
    n = 0;
    while (cyc != u_rdy_cyc && n < 60) begin idle(); n++; end
    check_eq("flush_rdy_reached", cyc, u_rdy_cyc);
    step_cycle(0, 0, 32'd0, 32'd0, 5'd0, 1);
    idle(); idle();
    check_eq("flush_wb_cnt", n_wb, 0);
    check_eq("flush_stall", bus.stall, 0);

    // Reset mid-BUSY, then a fresh issue restarts the unit
    clr_obs();
    step_cycle(0, 1, 32'd50, 32'd5, 5'd12, 0);
    repeat (10) idle();
    drive_zero();
    #2 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    clr_obs();
    step_cycle(1, 0, 32'd9, 32'd9, 5'd13, 0);
    wait_done(60);
    check_eq("post_rst_ctrl", n_ctrl_mult, 1);
    check_eq("post_rst_data", last_wb_data, 81);

    // Unit never answers: timeout abort
    clr_obs();
    u_mute = 1;
    step_cycle(1, 0, $urandom(), $urandom(), 5'd3, 0);
    wait_done(80);
    u_mute = 0;
    check_eq("to_pulse_cnt", n_to, 1);
    check_eq("to_wb_cnt", n_wb, 1);
    check_eq("to_wb_rd", last_wb_rd, 30);
    check_eq("to_wb_data", last_wb_data, 4);
    check_eq("to_wb_exc", last_wb_exc, 1);

    // Both issue lines high
    clr_obs();
    step_cycle(1, 1, 32'd1, 32'd2, 5'd4, 0);
    repeat (3) idle();
    check_eq("both_ierr_cnt", n_ierr, 1);
    check_eq("both_ctrl_cnt", n_ctrl_mult + n_ctrl_div, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r  = $urandom_range(0, 99);
      im = (r < 12) || (r >= 22 && r < 24);
      id = (r >= 12 && r < 24);
      stray_req   = ($urandom_range(0, 99) < 2);
      u_exc_force = ($urandom_range(0, 9) == 0);
      u_mute      = ($urandom_range(0, 19) == 0);
      step_cycle(im, id, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom(),
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom(),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()),
                 ($urandom_range(0, 99) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
